// File: rtl/systolic_array.sv
// -----------------------------------------------------------------------------
// systolic_array
//   Output-stationary N x N systolic array computing C = A x B for signed
//   N x N matrices. A is streamed in one column per cycle and B one row per
//   cycle over N consecutive valid cycles; after the wavefront has passed
//   through the grid, C is presented one row per cycle over N cycles.
//
// Parameters
//   DATAWIDTH  width of each signed A/B element (C elements are 2*DATAWIDTH)
//   N_SIZE     matrix dimension, N_SIZE >= 2
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   valid_in      current A column / B row is valid
//   matrix_a_in   slot i [i*DW +: DW] = A[i][k] for column k
//   matrix_b_in   slot j [j*DW +: DW] = B[k][j] for row k
//   valid_out     matrix_c_out holds one row of C
//   matrix_c_out  slot j [j*2DW +: 2DW] = C[r][j] for row r
//
// Build option
//   SYSTOLIC_SATURATE_EN  when defined, each accumulate saturates to the
//                         signed 2*DW range instead of wrapping. Ports and
//                         latency are the same in both builds.
// -----------------------------------------------------------------------------
module systolic_array #(
  parameter int DATAWIDTH = 16,
  parameter int N_SIZE    = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic [N_SIZE*DATAWIDTH-1:0]     matrix_a_in,
  input  logic [N_SIZE*DATAWIDTH-1:0]     matrix_b_in,
  output logic                            valid_out,
  output logic [N_SIZE*2*DATAWIDTH-1:0]   matrix_c_out
);

  localparam int DW = DATAWIDTH;
  localparam int AW = 2 * DATAWIDTH;
  localparam int CW = $clog2(4 * N_SIZE);

  // Edge indices counted from the batch start edge E0.
  localparam logic [CW-1:0] LAST_K         = CW'(N_SIZE - 1);
  localparam logic [CW-1:0] FIRST_OUT_EDGE = CW'(3 * N_SIZE - 2);
  localparam logic [CW-1:0] LAST_ROW       = CW'(N_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;

  logic            start;
  logic            capture;

  logic signed [DW-1:0] a_slot [N_SIZE];
  logic signed [DW-1:0] b_slot [N_SIZE];
  logic signed [DW-1:0] a_skew [N_SIZE];
  logic signed [DW-1:0] b_skew [N_SIZE];
  logic signed [DW-1:0] a_fwd  [N_SIZE][N_SIZE-1];
  logic signed [DW-1:0] b_fwd  [N_SIZE-1][N_SIZE];
  logic signed [AW-1:0] c_acc  [N_SIZE][N_SIZE];

  // Adds a product into an accumulator, wrapping or saturating per build.
  function automatic logic signed [AW-1:0] accumulate(
    input logic signed [AW-1:0] base,
    input logic signed [AW-1:0] addend
  );
`ifdef SYSTOLIC_SATURATE_EN
    logic [AW:0] sum;
    sum = {base[AW-1], base} + {addend[AW-1], addend};
    if (sum[AW] != sum[AW-1]) begin
      return sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
    return sum[AW-1:0];
`else
    return base + addend;
`endif
  endfunction

  // start is the batch-opening edge E0; capture covers every accepted k.
  assign start   = (state == IDLE) && valid_in;
  assign capture = ((state == IDLE) || (state == LOAD)) && valid_in;

  for (genvar s = 0; s < N_SIZE; s++) begin : g_slots
    assign a_slot[s] = matrix_a_in[s*DW +: DW];
    assign b_slot[s] = matrix_b_in[s*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (valid_in) next_state = LOAD;
      LOAD: begin
        if (!valid_in) begin
          next_state = IDLE;
        end else if (cnt == LAST_K) begin
          next_state = DRAIN;
        end
      end
      DRAIN:  if (cnt == FIRST_OUT_EDGE) next_state = OUTPUT;
      OUTPUT: if (cnt == LAST_ROW) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cnt holds the index of the upcoming edge during LOAD/DRAIN and the row
  // being presented during OUTPUT. Sitting in IDLE preloads 1 so that the
  // first LOAD edge is E1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE:    cnt <= CW'(1);
        LOAD:    cnt <= cnt + CW'(1);
        DRAIN:   cnt <= (cnt == FIRST_OUT_EDGE) ? '0 : cnt + CW'(1);
        OUTPUT:  cnt <= cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // Slot 0 feeds the corner PE with no delay. Every other slot runs through
  // a delay line as long as its index. On the start edge every register
  // output is treated as zero so leftovers from an aborted batch cannot leak
  // into the new one.
  assign a_skew[0] = capture ? a_slot[0] : '0;
  assign b_skew[0] = capture ? b_slot[0] : '0;

  for (genvar i = 1; i < N_SIZE; i++) begin : g_skew
    logic signed [DW-1:0] line_a [i];
    logic signed [DW-1:0] line_b [i];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < i; s++) begin
          line_a[s] <= '0;
          line_b[s] <= '0;
        end
      end else begin
        line_a[0] <= capture ? a_slot[i] : '0;
        line_b[0] <= capture ? b_slot[i] : '0;
        for (int s = 1; s < i; s++) begin
          line_a[s] <= start ? '0 : line_a[s-1];
          line_b[s] <= start ? '0 : line_b[s-1];
        end
      end
    end

    assign a_skew[i] = start ? '0 : line_a[i-1];
    assign b_skew[i] = start ? '0 : line_b[i-1];
  end

  // Processing element grid. Each PE multiplies its west and north operands,
  // accumulates in place, and forwards the operands east and south. The
  // accumulator restarts from zero on the start edge.
  for (genvar i = 0; i < N_SIZE; i++) begin : g_row
    for (genvar j = 0; j < N_SIZE; j++) begin : g_col
      logic signed [DW-1:0] a_op;
      logic signed [DW-1:0] b_op;
      logic signed [AW-1:0] prod;
      logic signed [AW-1:0] acc_q;

      if (j == 0) begin : g_west_edge
        assign a_op = a_skew[i];
      end else begin : g_west_pe
        assign a_op = start ? '0 : a_fwd[i][j-1];
      end

      if (i == 0) begin : g_north_edge
        assign b_op = b_skew[j];
      end else begin : g_north_pe
        assign b_op = start ? '0 : b_fwd[i-1][j];
      end

      assign prod = AW'(a_op) * AW'(b_op);

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
        end else begin
          acc_q <= accumulate(start ? '0 : acc_q, prod);
        end
      end

      assign c_acc[i][j] = acc_q;

      if (j < N_SIZE - 1) begin : g_east
        logic signed [DW-1:0] a_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            a_q <= '0;
          end else begin
            a_q <= a_op;
          end
        end
        assign a_fwd[i][j] = a_q;
      end

      if (i < N_SIZE - 1) begin : g_south
        logic signed [DW-1:0] b_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            b_q <= '0;
          end else begin
            b_q <= b_op;
          end
        end
        assign b_fwd[i][j] = b_q;
      end
    end
  end

  // Outputs follow the state register: OUTPUT lasts exactly N cycles and
  // cnt selects which accumulator row is visible.
  always_comb begin
    valid_out    = 1'b0;
    matrix_c_out = '0;
    if (state == OUTPUT) begin
      valid_out = 1'b1;
      for (int r = 0; r < N_SIZE; r++) begin
        if (cnt == CW'(r)) begin
          for (int j = 0; j < N_SIZE; j++) begin
            matrix_c_out[j*AW +: AW] = c_acc[r][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// -----------------------------------------------------------------------------
// tb_systolic_array
//   Self-checking bench for systolic_array (N=3, DW=16). Expected rows come
//   from a plain triple-loop matrix product on 64-bit integers, wrapped or
//   clamped to 32 bits to match the build option.
// -----------------------------------------------------------------------------
module tb_systolic_array;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 2 * DW;
  localparam int CWIDTH = N * AW;

  logic                clk_tb = 1'b0;
  logic                rst;
  logic                valid_in;
  logic [N*DW-1:0]     matrix_a_in;
  logic [N*DW-1:0]     matrix_b_in;
  logic                valid_out;
  logic [CWIDTH-1:0]   matrix_c_out;

  int tests_run    = 0;
  int tests_failed = 0;

  int                a_m [N][N];
  int                b_m [N][N];
  logic [CWIDTH-1:0] exp_rows [N];

  systolic_array #(
    .DATAWIDTH (DW),
    .N_SIZE    (N)
  ) dut (
    .clk          (clk_tb),
    .rst          (rst),
    .valid_in     (valid_in),
    .matrix_a_in  (matrix_a_in),
    .matrix_b_in  (matrix_b_in),
    .valid_out    (valid_out),
    .matrix_c_out (matrix_c_out)
  );

  always #5 clk_tb = ~clk_tb;

  task automatic compare(input string tag, input logic [CWIDTH-1:0] observed,
                         input logic [CWIDTH-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], accumulated in k order.
  function automatic void buildReference();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        longint sum;
        sum = 0;
        for (int k = 0; k < N; k++) begin
          sum = sum + longint'(a_m[i][k]) * longint'(b_m[k][j]);
`ifdef SYSTOLIC_SATURATE_EN
          if (sum > 64'sd2147483647)  sum = 64'sd2147483647;
          if (sum < -64'sd2147483648) sum = -64'sd2147483648;
`endif
        end
        exp_rows[i][j*AW +: AW] = sum[AW-1:0];
      end
    end
  endfunction

  task automatic randomMatrices();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] ta;
        logic [DW-1:0] tb;
        ta = DW'($urandom);
        tb = DW'($urandom);
        a_m[i][j] = int'($signed(ta));
        b_m[i][j] = int'($signed(tb));
      end
    end
  endtask

  task automatic resetDut();
    @(negedge clk_tb);
    rst         = 1'b1;
    valid_in    = 1'b0;
    matrix_a_in = '0;
    matrix_b_in = '0;
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb);
    rst = 1'b0;
  endtask

  // Drives columns of A and rows of B for the given number of cycles, then
  // drops valid_in. Returns on the negedge after the last driven edge.
  task automatic applyStimulus(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk_tb);
      valid_in = 1'b1;
      for (int s = 0; s < N; s++) begin
        matrix_a_in[s*DW +: DW] = a_m[s][k][DW-1:0];
        matrix_b_in[s*DW +: DW] = b_m[k][s][DW-1:0];
      end
      @(posedge clk_tb);
    end
    @(negedge clk_tb);
    valid_in    = 1'b0;
    matrix_a_in = '0;
    matrix_b_in = '0;
  endtask

  // Waits (bounded) for the first row, checks latency, every row, and that
  // valid_out drops after exactly N cycles.
  task automatic checkOutput(input string tag);
    int waited;
    waited = 0;
    do begin
      @(negedge clk_tb);
      waited++;
    end while (valid_out !== 1'b1 && waited < 40);
    compare({tag, "_latency"}, CWIDTH'(waited), CWIDTH'(2 * N - 1));
    for (int r = 0; r < N; r++) begin
      compare($sformatf("%s_valid%0d", tag, r), CWIDTH'(valid_out), CWIDTH'(1));
      compare($sformatf("%s_row%0d", tag, r), matrix_c_out, exp_rows[r]);
      @(negedge clk_tb);
    end
    compare({tag, "_valid_end"}, CWIDTH'(valid_out), CWIDTH'(0));
    compare({tag, "_data_end"}, matrix_c_out, '0);
  endtask

  task automatic watchSilence(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(negedge clk_tb);
      if (valid_out !== 1'b0) seen++;
    end
    compare(tag, CWIDTH'(seen), CWIDTH'(0));
  endtask

  initial begin
    rst         = 1'b1;
    valid_in    = 1'b0;
    matrix_a_in = '0;
    matrix_b_in = '0;

    // Reset state
    resetDut();
    compare("reset_valid", CWIDTH'(valid_out), CWIDTH'(0));
    compare("reset_data", matrix_c_out, '0);

    // Test 1: basic product
    a_m = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    b_m = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
    buildReference();
    applyStimulus(N);
    checkOutput("t1");

    // Test 2: reset, then a new pair with no residue
    resetDut();
    a_m = '{'{2, 3, 4}, '{5, 6, 7}, '{8, 9, 10}};
    b_m = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    buildReference();
    applyStimulus(N);
    checkOutput("t2");

    // Test 3: negated identity gives -B
    a_m = '{'{-1, 0, 0}, '{0, -1, 0}, '{0, 0, -1}};
    b_m = '{'{1, -2, 3}, '{4, 5, -6}, '{7, 8, 9}};
    buildReference();
    applyStimulus(N);
    checkOutput("t3");

    // Test 4: aborted batch emits nothing; then an abort immediately
    // followed by a full batch must still be exact.
    randomMatrices();
    applyStimulus(2);
    watchSilence("t4_abort_silent", 4 * N);
    randomMatrices();
    applyStimulus(2);
    randomMatrices();
    buildReference();
    applyStimulus(N);
    checkOutput("t4_after_abort");

    // Test 5: reset during DRAIN discards the batch
    randomMatrices();
    applyStimulus(N);
    @(negedge clk_tb);
    rst = 1'b1;
    @(negedge clk_tb);
    compare("t5_valid_after_rst", CWIDTH'(valid_out), CWIDTH'(0));
    compare("t5_data_after_rst", matrix_c_out, '0);
    rst = 1'b0;
    watchSilence("t5_no_rows", 4 * N);

    // Test 6: most negative operands everywhere
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = -32768;
        b_m[i][j] = -32768;
      end
    end
    buildReference();
    applyStimulus(N);
    checkOutput("t6_extreme");

    // Randomized batches against the reference product
    for (int t = 0; t < 8; t++) begin
      randomMatrices();
      buildReference();
      applyStimulus(N);
      checkOutput($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
